pad_event_queue: RTL
====================

// Module: pad_event_queue
// PURPOSE
//  Downstream of the PSX controller interface FSM. Snapshots the 16 active-low button levels after each completed poll.
//  Diffs each snapshot against the previous one and emits one press/release event per changed button.
//  Events go into a show-ahead FIFO, read by the CPU/MMIO side over a valid/ready handshake.
//  Analog axes are not handled here.
// PARAMETERS
//  FIFO_AW   4   log2 of FIFO depth (DEPTH = 2**FIFO_AW = 16 entries)
// PORTS
//  clk            in   1   system clock, same clock as the controller FSM
//  rst            in   1   synchronous reset, active high
//  control_state  in   8   one-hot FSM state from controller; IDLE=8'h01, ERROR=8'h80
//  err            in   1   controller protocol error level
//  buttons        in   16  active-low levels: 0 SLCT,1 LJOY,2 RJOY,3 STRT,4 UP,5 RGHT,6 DOWN,7 LEFT,
//                          8 L2,9 R2,10 L1,11 R1,12 TRI,13 CIR,14 XXX,15 SQU
//  evt_valid      out  1   FIFO non-empty
//  evt_data       out  8   head event: [7]=1 press/0 release, [6:4]=0, [3:0]=button index
//  evt_ready      in   1   consumer pop; pop occurs when evt_valid & evt_ready
//  evt_count      out  FIFO_AW+1  current occupancy
//  overrun        out  1   sticky: a completed poll was dropped
//  clr_ovr        in   1   clears overrun (rst also clears)
//  link_down      out  1   last poll ended in error
// BEHAVIOUR
//  Reset values: evt_valid=0, evt_data=8'h00, evt_count=0, overrun=0, link_down=0.
//  Reset also sets: prev snapshot=16'hFFFF (all released), FSM=WAIT, FIFO pointers=0.
//  poll_done: registered control_state was !=8'h01 and current ==8'h01 (a 1-cycle pulse).
//  FSM WAIT:
//   - on poll_done & !err -> latch cur=buttons, diff=prev^cur, link_down<=0, goto SCAN.
//   - on err: link_down<=1, snapshot untouched, stay in WAIT.
//  FSM SCAN, one event per cycle:
//   - i = lowest set bit of diff; event = {~cur[i],3'b0,i[3:0]}.
//   - if push allowed: write FIFO, clear diff[i], prev[i]<=cur[i].
//   - if push not allowed: hold (stall), nothing lost.
//   - diff==0 -> goto WAIT (cycle after last push); a SCAN with diff==0 on entry returns to WAIT next cycle.
//  poll_done while in SCAN: snapshot dropped, overrun<=1; scan continues on the old snapshot.
//  Latency: first event visible on evt_valid 2 cycles after poll_done (latch, push).
//  FIFO:
//   - push allowed = !full || pop (write-through-full permitted with a same-cycle pop).
//   - pop on empty is ignored.
//   - simultaneous push+pop: count unchanged.
//   - pointers wrap mod DEPTH.
//   - evt_data = mem[rd_ptr] when non-empty, else 8'h00.
//  clr_ovr and a new overrun in the same cycle -> overrun stays 1 (set wins).
//  Reset mid-scan: pending diff discarded, FIFO emptied, prev=16'hFFFF.
//   After reset, held buttons report as presses on the next poll.
// CONFIGURATION
//  PAD_EVT_TIMESTAMP_EN defined:
//   - adds port evt_ts out 16: a free-running 16-bit cycle/256 tick counter, wraps at 16'hFFFF.
//   - counter is sampled at poll_done and stored alongside every event from that poll.
//   - evt_ts is the head entry's stamp; 16'h0000 when empty; counter resets to 0.
//  Undefined: evt_ts port, counter and timestamp storage are absent; all other behaviour is identical.
// TESTING
//  1 rst; poll with buttons=16'hFFEF -> exactly one event 8'h84, evt_count=1; pop -> evt_valid=0.
//  2 poll with buttons=16'h7FFE -> events 8'h80 then 8'h8F in that order;
//    next poll 16'hFFFF -> 8'h00 then 8'h0F.
//  3 evt_ready=0; drive 16 press events -> evt_count=16, evt_valid=1.
//    Next poll with 4 releases -> scanner stalls. Another poll_done during stall -> overrun=1.
//    Drain -> all 20 events appear; clr_ovr -> overrun=0.
//  4 FIFO full, scanner stalled, evt_ready=1 -> one pop and one push per cycle, evt_count stays 16 until the scan ends.
//  5 control_state to 8'h80 with err=1, then to 8'h01 -> link_down=1, no events.
//    Next clean poll -> link_down=0, diffs against the last good snapshot.
//  6 rst asserted mid-scan with 3 events pending -> evt_count=0, evt_valid=0.
//    Next poll with same buttons -> full press set re-emitted.

Source files
------------

// File: rtl/pad_event_queue.sv
// ---------------------------------------------------------------------------
// pad_event_queue
//
// Purpose:
//   Sits behind the PSX controller interface FSM. After every completed poll
//   it snapshots the 16 active-low button levels, diffs them against the
//   previous snapshot and emits one press/release event per changed button
//   into a show-ahead FIFO that the CPU/MMIO side reads over valid/ready.
//
// Optional feature:
//   PAD_EVT_TIMESTAMP_EN - when defined, adds evt_ts. This is a free-running
//   cycle/256 tick counter that is sampled at poll_done and stored with
//   every event of that poll.
//
// Ports:
//   clk            in   1            system clock (same as controller FSM)
//   rst            in   1            synchronous reset, active high
//   control_state  in   8            one-hot controller state, IDLE=8'h01
//   err            in   1            controller protocol error level
//   buttons        in   16           active-low button levels
//   evt_valid      out  1            FIFO non-empty
//   evt_data       out  8            head event {press, 3'b0, index}
//   evt_ready      in   1            consumer pop request
//   evt_count      out  FIFO_AW+1    FIFO occupancy
//   overrun        out  1            sticky: a completed poll was dropped
//   clr_ovr        in   1            clears overrun
//   link_down      out  1            last poll ended in error
//   evt_ts         out  16           head event timestamp (optional)
//   dbg_state      out  1            scanner FSM state (0 WAIT, 1 SCAN)
//
// Handshake: the head entry is presented on evt_data whenever evt_valid is
// high. It is consumed on a cycle where evt_valid && evt_ready. evt_ready
// with evt_valid low has no effect.
// ---------------------------------------------------------------------------
module pad_event_queue #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         control_state,
    input  logic               err,
    input  logic [15:0]        buttons,
    output logic               evt_valid,
    output logic [7:0]         evt_data,
    input  logic               evt_ready,
    output logic [FIFO_AW:0]   evt_count,
    output logic               overrun,
    input  logic               clr_ovr,
    output logic               link_down,
`ifdef PAD_EVT_TIMESTAMP_EN
    output logic [15:0]        evt_ts,
`endif
    output logic               dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic {
        S_WAIT = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [7:0]         r_ctrl_state;
    logic [15:0]        r_prev;
    logic [15:0]        r_cur;
    logic [15:0]        r_diff;
    logic               r_overrun;
    logic               r_link_down;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic               w_poll_done;
    logic               w_latch;
    logic               w_push;
    logic               w_drop;
    logic               w_err_seen;
    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;
    logic [3:0]         w_idx;
    logic [7:0]         w_event;

    // A poll completes on the cycle the controller re-enters IDLE.
    assign w_poll_done = (r_ctrl_state != 8'h01) && (control_state == 8'h01);

    assign w_pop     = (r_count != '0) && evt_ready;
    assign w_full    = (r_count == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = !w_full || w_pop;

    // Lowest set bit of the pending diff; scanning downward lets the lowest win.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_diff[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_event = {~r_cur[w_idx], 3'b000, w_idx};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_err_seen   = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (err) begin
                    w_err_seen = 1'b1;
                end else if (w_poll_done) begin
                    w_latch      = 1'b1;
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                // The scanner keeps working on the old snapshot; the new
                // poll is lost and flagged.
                w_drop = w_poll_done;
                if (r_diff == 16'h0000) begin
                    w_next_state = S_WAIT;
                end else if (w_push_ok) begin
                    w_push = 1'b1;
                end
            end
            default: w_next_state = S_WAIT;
        endcase
    end

    assign dbg_state = r_state;

    // ---------------- snapshot / status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // IDLE here so a controller sitting in IDLE at reset release
            // does not look like a completed poll.
            r_ctrl_state <= 8'h01;
            r_prev       <= 16'hFFFF;
            r_cur        <= 16'hFFFF;
            r_diff       <= 16'h0000;
            r_overrun    <= 1'b0;
            r_link_down  <= 1'b0;
        end else begin
            r_ctrl_state <= control_state;
            if (w_latch) begin
                r_cur       <= buttons;
                r_diff      <= r_prev ^ buttons;
                r_link_down <= 1'b0;
            end
            if (w_err_seen) begin
                r_link_down <= 1'b1;
            end
            // prev is updated bit by bit so a reset mid-scan never leaves
            // it claiming events that were never delivered.
            if (w_push) begin
                r_diff[w_idx] <= 1'b0;
                r_prev[w_idx] <= r_cur[w_idx];
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign overrun   = r_overrun;
    assign link_down = r_link_down;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_event;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign evt_count = r_count;

`ifdef PAD_EVT_TIMESTAMP_EN
    logic [7:0]  r_presc;
    logic [15:0] r_tick;
    logic [15:0] r_poll_ts;
    logic [15:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= 8'h00;
            r_tick    <= 16'h0000;
            r_poll_ts <= 16'h0000;
        end else begin
            r_presc <= r_presc + 8'h01;
            if (r_presc == 8'hFF) begin
                r_tick <= r_tick + 16'h0001;
            end
            if (w_latch) begin
                r_poll_ts <= r_tick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ts_mem[r_wr_ptr] <= r_poll_ts;
        end
    end

    assign evt_ts = evt_valid ? r_ts_mem[r_rd_ptr] : 16'h0000;
`endif

endmodule
